// File: rtl/i2c_shift_engine.sv
// i2c_shift_engine: bit-level SDA shifter for one I2C byte/word frame.
// Transmits LoadData while sampling InputBit, then runs one ACK slot.
// Ports:
//   Clk, Rst        clock, async active-high reset
//   Load, LoadData  start frame with word to send (all-ones to receive)
//   AckDriveIn      value driven in the ACK slot (0 = ACK)
//   ShiftEn         one strobe per SCL rising edge
//   Abort           cancel frame, release SDA
//   InputBit        sampled SDA
//   OutputBit       SDA drive (1 = released)
//   Buffer          shift register / received word
//   BitCount        data bits shifted this frame
//   AckBit          SDA sampled in the ACK slot
//   Busy, Done      frame active / end-of-frame pulse
module i2c_shift_engine #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Load,
    input  logic [WIDTH-1:0]               LoadData,
    input  logic                           AckDriveIn,
    input  logic                           ShiftEn,
    input  logic                           Abort,
    input  logic                           InputBit,
    output logic                           OutputBit,
    output logic [WIDTH-1:0]               Buffer,
    output logic [$clog2(WIDTH+1)-1:0]     BitCount,
    output logic                           AckBit,
    output logic                           Busy,
    output logic                           Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_buf;
    logic [CW-1:0]    r_cnt;
    logic             r_out;
    logic             r_ack;
    logic             r_done;
    logic             r_ackdrv;

    logic [WIDTH-1:0] w_shifted;
    logic             w_next_out;
    logic             w_first_out;
    logic             w_last;

    // The outgoing end is the MSB (MSB-first) or LSB; the received bit
    // fills the opposite end, so after WIDTH shifts Buffer is the rx word.
    assign w_shifted   = MSB_FIRST ? {r_buf[WIDTH-2:0], InputBit}
                                   : {InputBit, r_buf[WIDTH-1:1]};
    assign w_next_out  = MSB_FIRST ? r_buf[WIDTH-2] : r_buf[1];
    assign w_first_out = MSB_FIRST ? LoadData[WIDTH-1] : LoadData[0];
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_out    <= 1'b1;
            r_ack    <= 1'b1;
            r_done   <= 1'b0;
            r_ackdrv <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (Abort) begin
                r_state <= S_IDLE;
                r_out   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Load) begin
                            r_buf    <= LoadData;
                            r_cnt    <= '0;
                            r_ackdrv <= AckDriveIn;
                            r_out    <= w_first_out;
                            r_state  <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (ShiftEn) begin
                            r_buf <= w_shifted;
                            r_cnt <= r_cnt + CW'(1);
                            if (w_last) begin
                                r_out   <= r_ackdrv;
                                r_state <= S_ACK;
                            end else begin
                                r_out <= w_next_out;
                            end
                        end
                    end
                    S_ACK: begin
                        if (ShiftEn) begin
                            r_ack   <= InputBit;
                            r_out   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign OutputBit = r_out;
    assign Buffer    = r_buf;
    assign BitCount  = r_cnt;
    assign AckBit    = r_ack;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;

endmodule

// File: tb/tb_i2c_shift_engine.sv
// tb_i2c_shift_engine: three instances (8/MSB, 8/LSB, 16/MSB) checked
// against a frame-level model every cycle plus directed literal checks.
module tb_i2c_shift_engine;

    logic Clk;
    logic Rst;

    logic        ld[3];
    logic [31:0] ldata[3];
    logic        ackin[3];
    logic        sh[3];
    logic        ab[3];
    logic        ib[3];

    logic        d_ob[3];
    logic        d_ak[3];
    logic        d_bz[3];
    logic        d_dn[3];
    logic [7:0]  b0, b1;
    logic [15:0] b2;
    logic [3:0]  c0, c1;
    logic [4:0]  c2;

    int WID[3]  = '{8, 8, 16};
    bit MSBF[3] = '{1'b1, 1'b0, 1'b1};

    int ntot  = 0;
    int npass = 0;
    int ndone2 = 0;

    i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .Clk(Clk), .Rst(Rst), .Load(ld[0]), .LoadData(ldata[0][7:0]),
        .AckDriveIn(ackin[0]), .ShiftEn(sh[0]), .Abort(ab[0]),
        .InputBit(ib[0]), .OutputBit(d_ob[0]), .Buffer(b0),
        .BitCount(c0), .AckBit(d_ak[0]), .Busy(d_bz[0]), .Done(d_dn[0])
    );

    i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .Clk(Clk), .Rst(Rst), .Load(ld[1]), .LoadData(ldata[1][7:0]),
        .AckDriveIn(ackin[1]), .ShiftEn(sh[1]), .Abort(ab[1]),
        .InputBit(ib[1]), .OutputBit(d_ob[1]), .Buffer(b1),
        .BitCount(c1), .AckBit(d_ak[1]), .Busy(d_bz[1]), .Done(d_dn[1])
    );

    i2c_shift_engine #(.WIDTH(16), .MSB_FIRST(1'b1)) u2 (
        .Clk(Clk), .Rst(Rst), .Load(ld[2]), .LoadData(ldata[2][15:0]),
        .AckDriveIn(ackin[2]), .ShiftEn(sh[2]), .Abort(ab[2]),
        .InputBit(ib[2]), .OutputBit(d_ob[2]), .Buffer(b2),
        .BitCount(c2), .AckBit(d_ak[2]), .Busy(d_bz[2]), .Done(d_dn[2])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] dbuf(int i);
        if (i == 0) return 32'(b0);
        if (i == 1) return 32'(b1);
        return 32'(b2);
    endfunction

    function automatic logic [31:0] dbc(int i);
        if (i == 0) return 32'(c0);
        if (i == 1) return 32'(c1);
        return 32'(c2);
    endfunction

    // Frame-level model: the loaded word, how many strobes the frame has
    // taken, and the bits received so far (in arrival order).
    logic        m_act[3]  = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_tx[3]   = '{32'd0, 32'd0, 32'd0};
    int          m_k[3]    = '{0, 0, 0};
    logic [31:0] m_rx[3]   = '{32'd0, 32'd0, 32'd0};
    logic        m_drv[3]  = '{1'b1, 1'b1, 1'b1};
    logic        m_ack[3]  = '{1'b1, 1'b1, 1'b1};
    logic        m_done[3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge Clk or posedge Rst) begin
        for (int i = 0; i < 3; i++) begin
            if (Rst) begin
                m_act[i]  <= 1'b0;
                m_tx[i]   <= '0;
                m_k[i]    <= 0;
                m_rx[i]   <= '0;
                m_drv[i]  <= 1'b1;
                m_ack[i]  <= 1'b1;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (ab[i]) begin
                    m_act[i] <= 1'b0;
                end else if (!m_act[i]) begin
                    if (ld[i]) begin
                        m_act[i] <= 1'b1;
                        m_tx[i]  <= ldata[i];
                        m_k[i]   <= 0;
                        m_rx[i]  <= '0;
                        m_drv[i] <= ackin[i];
                    end
                end else if (sh[i]) begin
                    if (m_k[i] < WID[i]) begin
                        m_k[i] <= m_k[i] + 1;
                        if (MSBF[i])
                            m_rx[i] <= (m_rx[i] << 1) | 32'(ib[i]);
                        else
                            m_rx[i] <= m_rx[i] | (32'(ib[i]) << m_k[i]);
                    end else begin
                        m_ack[i]  <= ib[i];
                        m_act[i]  <= 1'b0;
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_buf(int i);
        logic [63:0] m, t, r;
        int k, w;
        w = WID[i];
        k = m_k[i];
        m = (64'd1 << w) - 64'd1;
        t = 64'(m_tx[i]);
        r = 64'(m_rx[i]);
        if (MSBF[i]) return 32'(((t << k) | r) & m);
        return 32'(((t >> k) | (r << (w - k))) & m);
    endfunction

    function automatic logic exp_ob(int i);
        if (!m_act[i]) return 1'b1;
        if (m_k[i] < WID[i])
            return MSBF[i] ? m_tx[i][WID[i]-1-m_k[i]] : m_tx[i][m_k[i]];
        return m_drv[i];
    endfunction

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
        ntot++;
        if (got === want) npass++;
        else $display("FAIL %s inst%0d t=%0t got=%h want=%h",
                      nm, i, $time, got, want);
    endtask

    always @(negedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("mdl_ob",  i, 32'(d_ob[i]), 32'(exp_ob(i)));
            chk("mdl_buf", i, dbuf(i), exp_buf(i));
            chk("mdl_bc",  i, dbc(i), 32'(m_k[i]));
            chk("mdl_ak",  i, 32'(d_ak[i]), 32'(m_ack[i]));
            chk("mdl_bz",  i, 32'(d_bz[i]), 32'(m_act[i]));
            chk("mdl_dn",  i, 32'(d_dn[i]), 32'(m_done[i]));
        end
    end

    always @(negedge Clk) if (d_dn[2] === 1'b1) ndone2++;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(int i, logic [31:0] d, logic a);
        ld[i] = 1'b1;
        ldata[i] = d;
        ackin[i] = a;
        cyc();
        ld[i] = 1'b0;
    endtask

    task automatic shift(int i, logic b);
        sh[i] = 1'b1;
        ib[i] = b;
        cyc();
        sh[i] = 1'b0;
    endtask

    task automatic abort(int i);
        ab[i] = 1'b1;
        cyc();
        ab[i] = 1'b0;
    endtask

    logic [7:0]  pat;
    logic [15:0] p16;

    initial begin
        for (int i = 0; i < 3; i++) begin
            ld[i] = 0; ldata[i] = 0; ackin[i] = 1;
            sh[i] = 0; ab[i] = 0; ib[i] = 0;
        end
        Rst = 1'b1;
        cyc();
        chk("rst_ob",  0, 32'(d_ob[0]), 32'd1);
        chk("rst_ak",  0, 32'(d_ak[0]), 32'd1);
        chk("rst_bz",  0, 32'(d_bz[0]), 32'd0);
        chk("rst_dn",  0, 32'(d_dn[0]), 32'd0);
        chk("rst_buf", 0, dbuf(0), 32'd0);
        chk("rst_bc",  0, dbc(0), 32'd0);
        Rst = 1'b0;
        cyc();

        // Transmit 0xA5 with NACK driven, SDA low throughout.
        pat = 8'hA5;
        load(0, 32'hA5, 1'b1);
        chk("tx_ob0", 0, 32'(d_ob[0]), 32'd1);
        for (int j = 1; j < 8; j++) begin
            shift(0, 1'b0);
            chk("tx_ob", 0, 32'(d_ob[0]), 32'(pat[7-j]));
        end
        shift(0, 1'b0);
        chk("tx_ackdrv", 0, 32'(d_ob[0]), 32'd1);
        chk("tx_bc8",    0, dbc(0), 32'd8);
        chk("tx_bz",     0, 32'(d_bz[0]), 32'd1);
        shift(0, 1'b0);
        chk("tx_done", 0, 32'(d_dn[0]), 32'd1);
        chk("tx_rel",  0, 32'(d_ob[0]), 32'd1);
        chk("tx_buf",  0, dbuf(0), 32'h00);
        chk("tx_ak",   0, 32'(d_ak[0]), 32'd0);
        chk("tx_idle", 0, 32'(d_bz[0]), 32'd0);
        cyc();
        chk("tx_done1", 0, 32'(d_dn[0]), 32'd0);

        // Receive 0x3C, drive ACK, remote releases in the ACK slot.
        pat = 8'h3C;
        load(0, 32'hFF, 1'b0);
        for (int j = 0; j < 8; j++) shift(0, pat[7-j]);
        chk("rx_ackdrv", 0, 32'(d_ob[0]), 32'd0);
        shift(0, 1'b1);
        chk("rx_buf",  0, dbuf(0), 32'h3C);
        chk("rx_ak",   0, 32'(d_ak[0]), 32'd1);
        chk("rx_done", 0, 32'(d_dn[0]), 32'd1);
        chk("rx_bc",   0, dbc(0), 32'd8);

        // LSB-first instance.
        pat = 8'h80;
        load(1, 32'h01, 1'b1);
        chk("lsb_ob0", 1, 32'(d_ob[1]), 32'd1);
        for (int j = 0; j < 8; j++) begin
            shift(1, pat[j]);
            if (j < 7) chk("lsb_ob", 1, 32'(d_ob[1]), 32'd0);
        end
        chk("lsb_buf", 1, dbuf(1), 32'h80);
        shift(1, 1'b0);
        chk("lsb_done", 1, 32'(d_dn[1]), 32'd1);

        // Abort after 3 strobes, with Load and ShiftEn also raised.
        load(0, 32'h5A, 1'b1);
        for (int j = 0; j < 3; j++) shift(0, 1'b1);
        ab[0] = 1'b1; sh[0] = 1'b1; ld[0] = 1'b1; ldata[0] = 32'h77;
        cyc();
        ab[0] = 1'b0; sh[0] = 1'b0; ld[0] = 1'b0;
        chk("ab_bz",  0, 32'(d_bz[0]), 32'd0);
        chk("ab_ob",  0, 32'(d_ob[0]), 32'd1);
        chk("ab_bc",  0, dbc(0), 32'd3);
        chk("ab_buf", 0, dbuf(0), 32'hD7);
        chk("ab_dn",  0, 32'(d_dn[0]), 32'd0);
        cyc();
        chk("ab_dn1", 0, 32'(d_dn[0]), 32'd0);
        load(0, 32'h33, 1'b1);
        chk("ab_rbc",  0, dbc(0), 32'd0);
        chk("ab_rbz",  0, 32'(d_bz[0]), 32'd1);
        chk("ab_rbuf", 0, dbuf(0), 32'h33);
        abort(0);

        // Reset pulse between edges mid-frame.
        load(0, 32'hC3, 1'b1);
        for (int j = 0; j < 5; j++) shift(0, 1'b0);
        Rst = 1'b1;
        #2;
        chk("mr_ob",  0, 32'(d_ob[0]), 32'd1);
        chk("mr_buf", 0, dbuf(0), 32'd0);
        chk("mr_bc",  0, dbc(0), 32'd0);
        chk("mr_bz",  0, 32'(d_bz[0]), 32'd0);
        chk("mr_ak",  0, 32'(d_ak[0]), 32'd1);
        chk("mr_dn",  0, 32'(d_dn[0]), 32'd0);
        Rst = 1'b0;
        shift(0, 1'b1);
        chk("idle_sh_buf", 0, dbuf(0), 32'd0);
        chk("idle_sh_bz",  0, 32'(d_bz[0]), 32'd0);
        chk("idle_sh_bc",  0, dbc(0), 32'd0);
        load(0, 32'hC3, 1'b1);
        load(0, 32'h11, 1'b0);
        chk("busy_ld_buf", 0, dbuf(0), 32'hC3);
        chk("busy_ld_bc",  0, dbc(0), 32'd0);
        shift(0, 1'b1);
        chk("busy_sh_buf", 0, dbuf(0), 32'h87);
        for (int j = 0; j < 7; j++) shift(0, 1'b0);
        chk("busy_ackdrv", 0, 32'(d_ob[0]), 32'd1);
        abort(0);
        ld[0] = 1'b1; ldata[0] = 32'h96; ackin[0] = 1'b0;
        sh[0] = 1'b1; ib[0] = 1'b1;
        cyc();
        ld[0] = 1'b0; sh[0] = 1'b0;
        chk("ldsh_buf", 0, dbuf(0), 32'h96);
        chk("ldsh_bc",  0, dbc(0), 32'd0);
        chk("ldsh_ob",  0, 32'(d_ob[0]), 32'd1);
        abort(0);

        // 16-bit back-to-back frames, second Load in the Done cycle.
        p16 = 16'hBEEF;
        load(2, 32'h1234, 1'b0);
        for (int j = 0; j < 16; j++) shift(2, p16[15-j]);
        shift(2, 1'b0);
        chk("w16_done", 2, 32'(d_dn[2]), 32'd1);
        chk("w16_buf",  2, dbuf(2), 32'hBEEF);
        chk("w16_bc",   2, dbc(2), 32'd16);
        load(2, 32'hABCD, 1'b1);
        chk("w16_bz",  2, 32'(d_bz[2]), 32'd1);
        chk("w16_ld",  2, dbuf(2), 32'hABCD);
        chk("w16_dn0", 2, 32'(d_dn[2]), 32'd0);
        chk("w16_ob",  2, 32'(d_ob[2]), 32'd1);
        p16 = 16'h0F0F;
        for (int j = 0; j < 16; j++) shift(2, p16[15-j]);
        shift(2, 1'b1);
        chk("w16_buf2", 2, dbuf(2), 32'h0F0F);
        chk("w16_ak",   2, 32'(d_ak[2]), 32'd1);
        cyc();
        cyc();
        chk("w16_ndone", 2, 32'(ndone2), 32'd2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/i2c_shift_engine.md
I2C_SHIFT_ENGINE -- requirements
Module: i2c_shift_engine

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of data bits per frame; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB transmitted/received first; 0 = LSB first.
REQ-003 Port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port Rst  input  1  reset, asynchronous, active-high.
REQ-005 Port Load  input  1  start-of-frame strobe; captures LoadData and AckDriveIn.
REQ-006 Port LoadData  input  WIDTH  word to transmit (all-ones when receiving).
REQ-007 Port AckDriveIn  input  1  value driven during the ACK slot (0 = ACK, 1 = NACK/release).
REQ-008 Port ShiftEn  input  1  one-cycle bit-slot strobe, asserted once per SCL rising edge by the controller.
REQ-009 Port Abort  input  1  synchronous frame cancel.
REQ-010 Port InputBit  input  1  sampled SDA value.
REQ-011 Port OutputBit  output  1  SDA drive value (1 = released).
REQ-012 Port Buffer  output  WIDTH  shift register contents; holds the received word after Done.
REQ-013 Port BitCount  output  clog2(WIDTH+1)  data bits shifted in the current frame.
REQ-014 Port AckBit  output  1  InputBit sampled in the ACK slot.
REQ-015 Port Busy  output  1  high in SHIFT or ACK state.
REQ-016 Port Done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 States: IDLE, SHIFT, ACK; encoding is free; Busy = (state != IDLE).
REQ-018 IDLE + Load: Buffer <= LoadData, BitCount <= 0, latch AckDriveIn, state -> SHIFT, OutputBit <= first bit (LoadData[WIDTH-1] if MSB_FIRST, else LoadData[0]).
REQ-019 SHIFT + ShiftEn: Buffer shifts one place toward the outgoing end, InputBit enters at the vacated end (bit 0 if MSB_FIRST, bit WIDTH-1 otherwise), BitCount increments, OutputBit <= next outgoing bit, all in the same edge.
REQ-020 SHIFT + ShiftEn with BitCount = WIDTH-1: state -> ACK, BitCount <= WIDTH, OutputBit <= latched AckDriveIn.
REQ-021 ACK + ShiftEn: AckBit <= InputBit, OutputBit <= 1, Done = 1 for exactly that following cycle, state -> IDLE; Buffer and BitCount hold.
REQ-022 ShiftEn in IDLE is ignored; no state, Buffer or output change.
REQ-023 Load while Busy is ignored; the frame in progress continues.
REQ-024 Load and ShiftEn together in IDLE: Load takes effect; ShiftEn is discarded.
REQ-025 Abort (any state) has priority over Load and ShiftEn: state -> IDLE, OutputBit <= 1, Done stays 0, Buffer/BitCount/AckBit hold.
REQ-026 Done is never asserted for two consecutive cycles; a new Load is accepted in the cycle Done is high.
REQ-027 Output latency: every output reflects an accepted strobe on the cycle after the sampling edge; no combinational path from inputs to outputs.

Reset
REQ-028 Rst high forces immediately, independent of Clk: state IDLE, Buffer all-zeros, BitCount 0, OutputBit 1, AckBit 1, Busy 0, Done 0.
REQ-029 Rst asserted mid-frame abandons the frame with no Done pulse; after release the block waits for Load.
REQ-030 Rst is synchronised externally; the block requires only that Rst deassertion meets Clk recovery/removal.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, Load 0xA5, AckDriveIn=1, InputBit=0 throughout, 9 ShiftEn -> OutputBit sequence 1,0,1,0,0,1,0,1 then 1; Done one cycle after 9th strobe; Buffer 0x00; AckBit 0.
REQ-032 Receive: Load 0xFF, AckDriveIn=0, InputBit pattern 0x3C MSB first, 9th slot InputBit=1 -> Buffer 0x3C, OutputBit 0 during ACK slot, AckBit 1, Done pulse.
REQ-033 MSB_FIRST=0, Load 0x01 -> first OutputBit 1, then seven 0s; InputBit 0x80 pattern LSB first -> Buffer 0x80.
REQ-034 Abort after 3 ShiftEn -> Busy 0, OutputBit 1, no Done, BitCount 3; following Load restarts with BitCount 0.
REQ-035 Rst pulse between Clk edges after 5 ShiftEn -> outputs at reset values before the next edge; Load during Busy and ShiftEn in IDLE produce no change.
REQ-036 WIDTH=16 back-to-back frames with Load in the Done cycle -> second frame starts without a gap, Done pulses count 2.
